// File: rtl/rshf_iter.sv
// rshf_iter: iterative right shifter (logical or arithmetic), STEP bits per clock.
// A start accepted while ready loads the operand; SHIFT repeats until the count
// runs out, then DONE raises done for one cycle with shift_out already updated.
module rshf_iter #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1   // legal: 1, 2, 4, 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] shift_in,
   input  logic [4:0]       shamt,
   input  logic             arith,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] shift_out,
   output logic [1:0]       fsm_state
);

   // Handshake: a request is taken on a rising edge where start=1 and ready=1
   // (ready is high in IDLE and DONE, so requests can run back to back). While
   // busy=1, start is ignored. done is a single-cycle pulse; shift_out is valid
   // from that cycle and holds until the next accepted request completes.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [4:0] STEP_AMT = 5'(STEP);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   work;
   logic [WIDTH-1:0]   work_nxt;
   logic [2*WIDTH-1:0] ext;
   logic [4:0]         cnt;
   logic [4:0]         k;
   logic               fill;
   logic               accept;

   assign accept    = start & ready;
   assign ready     = (state == IDLE) || (state == DONE);
   assign busy      = (state == SHIFT);
   assign done      = (state == DONE);
   assign fsm_state = state;

   // Per-cycle shift amount, clipped so the last step never overshoots.
   assign k = (cnt < STEP_AMT) ? cnt : STEP_AMT;

   // Fill bits enter from the top; the fill is frozen at acceptance so the sign
   // always comes from the original operand.
   assign ext      = {{WIDTH{fill}}, work} >> k;
   assign work_nxt = ext[WIDTH-1:0];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = (shamt == 5'd0) ? DONE : SHIFT;
         SHIFT:   if (cnt == k) state_nxt = DONE;
         DONE:    if (start) state_nxt = (shamt == 5'd0) ? DONE : SHIFT;
                  else       state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: load on acceptance, shift while in SHIFT, publish the final value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work      <= '0;
         cnt       <= '0;
         fill      <= 1'b0;
         shift_out <= '0;
      end else if (accept) begin
         work <= shift_in;
         cnt  <= shamt;
         fill <= arith & shift_in[WIDTH-1];
         if (shamt == 5'd0) shift_out <= shift_in;
      end else if (state == SHIFT) begin
         work <= work_nxt;
         cnt  <= cnt - k;
         if (cnt == k) shift_out <= work_nxt;
      end
   end

endmodule
